pn_spike_unpacker: RTL and testbench

PN_SPIKE_UNPACKER -- requirements
Module: pn_spike_unpacker

---
 rtl/pn_spike_unpacker.sv | 146 ++++++++++++++
 tb/tb_pn_spike_unpacker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_spike_unpacker.sv
// Spike/parameter packet unpacker: buffers 48-bit packets in a FIFO and expands
// each one into zero, one or two single-address ops on a valid/ready output.
module pn_spike_unpacker #(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      kill,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_addr,
    input  logic [31:0]               in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_op,
    output logic [6:0]                out_addr,
    output logic [31:0]               out_data,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [7:0]                null_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO_A = 2'd2;
    localparam logic [1:0] S_TWO_B = 2'd3;

    localparam logic [1:0] K_NULL = 2'd0;
    localparam logic [1:0] K_ONE  = 2'd1;
    localparam logic [1:0] K_TWO  = 2'd2;

    logic [47:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [1:0]  state;
    logic [6:0]  hi_addr;
    logic        empty;
    logic        full;
    logic        push;
    logic        load;
    logic        pop;
    logic [47:0] head;
    logic [18:0] dec;
    logic [1:0]  dec_kind;
    logic [2:0]  dec_op;
    logic [6:0]  dec_lo;
    logic [6:0]  dec_hi;

    // Returns {kind, op, first address, second address} for one packet word.
    function automatic logic [18:0] decode_pkt(input logic [15:0] a);
        logic [1:0] kind;
        logic [2:0] op;
        kind = K_ONE;
        op   = 3'b000;
        if (a[15]) begin
            case (a[13:12])
                2'b01:   op = 3'b100;
                2'b00:   op = 3'b101;
                2'b10:   op = 3'b110;
                default: op = 3'b111;
            endcase
        end else if (a[14]) begin
            op = 3'b001;
        end else if (a[13:0] == 14'd0) begin
            kind = K_NULL;
        end else if (a[13:7] != 7'd0) begin
            kind = K_TWO;
        end
        return {kind, op, a[6:0], a[13:7]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = !full;
    assign fifo_count = wr_ptr - rd_ptr;
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign dec        = decode_pkt(head[47:32]);
    assign dec_kind   = dec[18:17];
    assign dec_op     = dec[16:14];
    assign dec_lo     = dec[13:7];
    assign dec_hi     = dec[6:0];

    // The next packet is fetched from IDLE, or on the final transfer of the current one.
    assign load = (state == S_IDLE) ||
                  (((state == S_ONE) || (state == S_TWO_B)) && out_ready);
    assign pop  = load && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_op    <= 3'b000;
            out_addr  <= 7'd0;
            out_data  <= 32'd0;
            hi_addr   <= 7'd0;
            null_cnt  <= 8'd0;
        end else if (kill) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (load) begin
                if (empty || (dec_kind == K_NULL)) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                    if (!empty) begin
                        null_cnt <= sat_inc(null_cnt);
                    end
                end else begin
                    out_valid <= 1'b1;
                    out_op    <= dec_op;
                    out_addr  <= dec_lo;
                    out_data  <= head[31:0];
                    hi_addr   <= dec_hi;
                    state     <= (dec_kind == K_TWO) ? S_TWO_A : S_ONE;
                end
            end else if ((state == S_TWO_A) && out_ready) begin
                out_addr <= hi_addr;
                state    <= S_TWO_B;
            end
        end
    end

endmodule

// File: tb/tb_pn_spike_unpacker.sv
// Scoreboard bench for pn_spike_unpacker: expected ops are queued as packets are
// driven and compared in order whenever an output transfer occurs.
module tb_pn_spike_unpacker;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          kill = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_addr = 16'd0;
    logic [31:0]   in_data = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    out_op;
    logic [6:0]    out_addr;
    logic [31:0]   out_data;
    logic [CW-1:0] fifo_count;
    logic [7:0]    null_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [41:0] sb [$];
    logic [41:0] mon_exp;

    pn_spike_unpacker #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .kill       (kill),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .null_cnt   (null_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL op_unexpected: got op=%b addr=%h data=%h, required no op",
                         out_op, out_addr, out_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({out_op, out_addr, out_data} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL op_stream: got op=%b addr=%h data=%h, required op=%b addr=%h data=%h",
                             out_op, out_addr, out_data, mon_exp[41:39], mon_exp[38:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_op(input logic [2:0] op, input logic [6:0] addr, input logic [31:0] data);
        sb.push_back({op, addr, data});
    endtask

    task automatic push_pkt(input logic [15:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        in_addr  = a;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d ops outstanding, required 0", sb.size());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || fifo_count !== '0) begin
            miscompares++;
            $display("FAIL drain_idle: out_valid=%b fifo_count=%0d, required 0/0", out_valid, fifo_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_op !== 3'b000 || out_addr !== 7'd0 || out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b op=%b addr=%h data=%h, required all zero",
                     out_valid, out_op, out_addr, out_data);
        end
        vectors++;
        if (fifo_count !== '0 || null_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_counts: fifo_count=%0d null_cnt=%0d, required 0/0", fifo_count, null_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_two_op();
        out_ready = 1'b1;
        expect_op(3'b000, 7'd5, 32'hDEADBEEF);
        expect_op(3'b000, 7'd3, 32'hDEADBEEF);
        push_pkt(16'h0185, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_addr !== 7'd5) begin
            miscompares++;
            $display("FAIL two_op_first: valid=%b addr=%h, required 1/05", out_valid, out_addr);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_addr !== 7'd3) begin
            miscompares++;
            $display("FAIL two_op_second: valid=%b addr=%h, required 1/03", out_valid, out_addr);
        end
        drain();
    endtask

    task automatic test_null();
        out_ready = 1'b1;
        expect_op(3'b001, 7'h12, 32'h0000_0002);
        push_pkt(16'h0000, 32'h0000_0001);
        push_pkt(16'h4012, 32'h0000_0002);
        drain();
        vectors++;
        if (null_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL null_count: got %0d, required 1", null_cnt);
        end
    endtask

    task automatic test_params();
        out_ready = 1'b1;
        expect_op(3'b100, 7'd3, 32'h1111_0003);
        expect_op(3'b101, 7'd4, 32'h1111_0004);
        expect_op(3'b110, 7'd5, 32'h1111_0005);
        expect_op(3'b111, 7'd6, 32'h1111_0006);
        push_pkt(16'h9003, 32'h1111_0003);
        push_pkt(16'h8004, 32'h1111_0004);
        push_pkt(16'hA005, 32'h1111_0005);
        push_pkt(16'hB006, 32'h1111_0006);
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_op(3'b000, 7'(i + 16), 32'hB2B0_0000 + 32'(i));
            push_pkt(16'(i + 16), 32'hB2B0_0000 + 32'(i));
            vectors++;
            if (fifo_count !== CW'(1)) begin
                miscompares++;
                $display("FAIL b2b_count[%0d]: got %0d, required 1", i, fifo_count);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            expect_op(3'b000, 7'(i), 32'hBB00_0000 + 32'(i));
            push_pkt(16'(i), 32'hBB00_0000 + 32'(i));
        end
        vectors++;
        if (fifo_count !== CW'(DEPTH - 1) || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_count: fifo_count=%0d valid=%b, required %0d/1", fifo_count, out_valid, DEPTH - 1);
        end
        expect_op(3'b000, 7'(DEPTH + 1), 32'hBB00_0000 + 32'(DEPTH + 1));
        push_pkt(16'(DEPTH + 1), 32'hBB00_0000 + 32'(DEPTH + 1));
        vectors++;
        if (in_ready !== 1'b0 || fifo_count !== CW'(DEPTH)) begin
            miscompares++;
            $display("FAIL bp_full: in_ready=%b fifo_count=%0d, required 0/%0d", in_ready, fifo_count, DEPTH);
        end
        @(negedge clk);
        in_addr  = 16'h0055;
        in_data  = 32'hBAD0_BAD0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        vectors++;
        if (fifo_count !== CW'(DEPTH) || out_addr !== 7'd1) begin
            miscompares++;
            $display("FAIL bp_ignored: fifo_count=%0d addr=%h, required %0d/01", fifo_count, out_addr, DEPTH);
        end
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_kill();
        logic [7:0] nc;
        nc = null_cnt;
        out_ready = 1'b0;
        push_pkt(16'h0185, 32'hC0DE_0001);
        push_pkt(16'h0009, 32'hC0DE_0002);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_addr !== 7'd5 || fifo_count !== CW'(1)) begin
            miscompares++;
            $display("FAIL kill_pre: valid=%b addr=%h count=%0d, required 1/05/1", out_valid, out_addr, fifo_count);
        end
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || fifo_count !== '0 || null_cnt !== nc) begin
            miscompares++;
            $display("FAIL kill_flush: valid=%b count=%0d null_cnt=%0d, required 0/0/%0d",
                     out_valid, fifo_count, null_cnt, nc);
        end
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_null_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            push_pkt(16'h0000, 32'(i));
        end
        drain();
        vectors++;
        if (null_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL null_saturate: got %0d, required 255", null_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        expect_op(3'b000, 7'd5, 32'hAB00_0000);
        push_pkt(16'h0185, 32'hAB00_0000);
        push_pkt(16'h0001, 32'hAB00_0001);
        push_pkt(16'h0002, 32'hAB00_0002);
        push_pkt(16'h0003, 32'hAB00_0003);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_addr !== 7'd3 || fifo_count !== CW'(3)) begin
            miscompares++;
            $display("FAIL rst_mid_pre: valid=%b addr=%h count=%0d, required 1/03/3", out_valid, out_addr, fifo_count);
        end
        #2 rst = 1'b1;
        #1;
        sb.delete();
        vectors++;
        if (out_valid !== 1'b0 || out_op !== 3'b000 || out_addr !== 7'd0 || out_data !== 32'd0 ||
            fifo_count !== '0 || null_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL rst_mid_async: valid=%b op=%b addr=%h data=%h count=%0d null=%0d, required all zero",
                     out_valid, out_op, out_addr, out_data, fifo_count, null_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        expect_op(3'b000, 7'd7, 32'h7777_7777);
        push_pkt(16'h0007, 32'h7777_7777);
        drain();
    endtask

    initial begin
        test_reset();
        test_two_op();
        test_null();
        test_params();
        test_back_to_back();
        test_backpressure();
        test_kill();
        test_null_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
